// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//
// Contents:
//   OP_MULT / OP_MULTU / OP_DIV / OP_DIVU : op_i encodings
//   state_e                               : FSM states (IDLE, CALC, FIX, DONE)
//   abs_val / neg_val                     : width-parameterised two's complement
//                                           helpers. They work on a MAX_W-bit
//                                           container; the caller zero-extends
//                                           its operand, passes the real width
//                                           and casts the result back down.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Widest value the helpers handle (covers a 2*DATA_WIDTH product).
  localparam int MAX_W = 256;

  // Two's complement negation of the low w bits of v; upper bits are zeroed.
  function automatic logic [MAX_W-1:0] neg_val(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    return (~v + MAX_W'(1)) & mask;
  endfunction

  // Magnitude of the w-bit signed value held in the low bits of v.
  // The most negative value maps to itself, which reads correctly as unsigned.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    if (|(v & (MAX_W'(1) << (w - 1)))) begin
      return neg_val(v, w);
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single iteration of the multiply/divide datapath.
//
// Ports:
//   is_div_i  in  1             1 = restoring-divide step, 0 = shift-add step
//   acc_i     in  2*DATA_WIDTH  current accumulator
//   opnd_i    in  DATA_WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_o     out 2*DATA_WIDTH  accumulator after one iteration
//
// Multiply layout: acc = {partial product high half, remaining multiplier bits}.
//   The LSB selects add-or-pass, then the whole thing shifts right by one with
//   the adder carry entering at the top.
// Divide layout:   acc = {partial remainder, remaining dividend bits / quotient}.
//   Shift left one, trial-subtract the divisor from the upper half, and shift
//   in the quotient bit at the bottom.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div_i,
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   opnd_i,
  output logic [2*DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH:0] mul_sum;
  logic [DATA_WIDTH:0] div_shift;
  logic [DATA_WIDTH:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]} +
                (acc_i[0] ? {1'b0, opnd_i} : {(DATA_WIDTH+1){1'b0}});
    // Partial remainder is always below the divisor, so the shifted value
    // fits in DATA_WIDTH+1 bits and the top bit of the difference is a clean
    // borrow flag.
    div_shift = {acc_i[2*DATA_WIDTH-1:DATA_WIDTH], acc_i[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_i};

    if (is_div_i) begin
      if (!div_diff[DATA_WIDTH]) begin
        acc_o = {div_diff[DATA_WIDTH-1:0], acc_i[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {div_shift[DATA_WIDTH-1:0], acc_i[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   rst_i    in   1   asynchronous active-high reset
//   start_i  in   1   launch an operation (only honoured in IDLE)
//   op_i     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i  in   W   rs: multiplicand / dividend
//   data2_i  in   W   rt: multiplier / divisor
//   flush_i  in   1   abort in-flight operation (CALC/FIX), blocks launch in IDLE
//   hi_we_i  in   1   direct HI write (IDLE only)
//   lo_we_i  in   1   direct LO write (IDLE only)
//   wdata_i  in   W   direct write data
//   busy_o   out  1   high in CALC and FIX
//   done_o   out  1   one-cycle pulse in the cycle HI/LO first show a new result
//   div0_o   out  1   last operation was a divide by zero (cleared on launch)
//   hi_o     out  W   HI register (product high half / remainder)
//   lo_o     out  W   LO register (product low half / quotient)
//
// Timing: start sampled at edge N -> CALC for DATA_WIDTH cycles -> FIX for one
// cycle (sign fix-up and HI/LO write) -> DONE for one cycle. done_o is high in
// cycle N+DATA_WIDTH+2. Signed ops iterate on magnitudes; signs are restored
// in FIX. DATA_WIDTH must be even and at least 4.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic                  flush_i,
  input  logic                  hi_we_i,
  input  logic                  lo_we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div0_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_res_q, neg_res_d;   // product / quotient negative
  logic                  neg_rem_q, neg_rem_d;   // remainder negative (dividend sign)
  logic                  div0_q, div0_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  logic                  op_signed;
  logic [DATA_WIDTH-1:0] mag1;
  logic [DATA_WIDTH-1:0] mag2;
  logic [ACC_W-1:0]      prod;
  logic [ACC_W-1:0]      step_acc;

  muldiv_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_signed = 1'b0;
    mag1      = '0;
    mag2      = '0;
    prod      = '0;

    unique case (state_q)
      IDLE: begin
        // Direct writes land first; a same-cycle launch still proceeds and its
        // result overwrites HI/LO later.
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && !flush_i) begin
          op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
          mag1      = op_signed ? DATA_WIDTH'(abs_val(MAX_W'(data1_i), DATA_WIDTH)) : data1_i;
          mag2      = op_signed ? DATA_WIDTH'(abs_val(MAX_W'(data2_i), DATA_WIDTH)) : data2_i;
          is_div_d  = (op_i == OP_DIV) || (op_i == OP_DIVU);
          if (is_div_d) begin
            acc_d  = {{DATA_WIDTH{1'b0}}, mag1};
            opnd_d = mag2;
          end else begin
            acc_d  = {{DATA_WIDTH{1'b0}}, mag2};
            opnd_d = mag1;
          end
          neg_res_d = op_signed & (data1_i[DATA_WIDTH-1] ^ data2_i[DATA_WIDTH-1]);
          neg_rem_d = op_signed & data1_i[DATA_WIDTH-1];
          div0_d    = 1'b0;
          cnt_d     = CNT_W'(DATA_WIDTH);
          state_d   = CALC;
        end
      end

      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end

      FIX: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // Divide by zero ran the full iteration count: the quotient came
            // out all ones and the remainder is |dividend|, which the sign
            // fix-up below turns back into the original dividend.
            if (opnd_q == '0) begin
              lo_d   = '1;
              div0_d = 1'b1;
            end else if (neg_res_q) begin
              lo_d = DATA_WIDTH'(neg_val(MAX_W'(acc_q[DATA_WIDTH-1:0]), DATA_WIDTH));
            end else begin
              lo_d = acc_q[DATA_WIDTH-1:0];
            end
            if (neg_rem_q) begin
              hi_d = DATA_WIDTH'(neg_val(MAX_W'(acc_q[ACC_W-1:DATA_WIDTH]), DATA_WIDTH));
            end else begin
              hi_d = acc_q[ACC_W-1:DATA_WIDTH];
            end
          end else begin
            prod = neg_res_q ? ACC_W'(neg_val(MAX_W'(acc_q), ACC_W)) : acc_q;
            hi_d = prod[ACC_W-1:DATA_WIDTH];
            lo_d = prod[DATA_WIDTH-1:0];
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == CALC) || (state_q == FIX);
  assign done_o = (state_q == DONE);
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit at DATA_WIDTH 32 and 8.
// Stimulus pushes the expected {div0, HI, LO} into a per-instance queue; a
// monitor per instance pops and compares whenever done_o is seen.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rst8;
  logic        start32, start8;
  logic [1:0]  op;
  logic [31:0] d1, d2, wdata;
  logic        flush, hi_we, lo_we;

  logic        busy32, done32, div0_32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, div0_8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp32_q[$];
  logic [16:0] exp8_q[$];
  logic [64:0] e32;
  logic [16:0] e8;

  muldiv_unit #(.DATA_WIDTH(32)) u_dut32 (
    .clk_i   (clk),
    .rst_i   (rst32),
    .start_i (start32),
    .op_i    (op),
    .data1_i (d1),
    .data2_i (d2),
    .flush_i (flush),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata),
    .busy_o  (busy32),
    .done_o  (done32),
    .div0_o  (div0_32),
    .hi_o    (hi32),
    .lo_o    (lo32)
  );

  muldiv_unit #(.DATA_WIDTH(8)) u_dut8 (
    .clk_i   (clk),
    .rst_i   (rst8),
    .start_i (start8),
    .op_i    (op),
    .data1_i (d1[7:0]),
    .data2_i (d2[7:0]),
    .flush_i (flush),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata[7:0]),
    .busy_o  (busy8),
    .done_o  (done8),
    .div0_o  (div0_8),
    .hi_o    (hi8),
    .lo_o    (lo8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (exp32_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut32_unexpected_done: got done_o=1, expected no result (t=%0t)", $time);
      end else begin
        e32 = exp32_q.pop_front();
        chk("dut32_hi", 64'(hi32), 64'(e32[63:32]));
        chk("dut32_lo", 64'(lo32), 64'(e32[31:0]));
        chk("dut32_div0", 64'(div0_32), 64'(e32[64]));
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_unexpected_done: got done_o=1, expected no result (t=%0t)", $time);
      end else begin
        e8 = exp8_q.pop_front();
        chk("dut8_hi", 64'(hi8), 64'(e8[15:8]));
        chk("dut8_lo", 64'(lo8), 64'(e8[7:0]));
        chk("dut8_div0", 64'(div0_8), 64'(e8[16]));
      end
    end
  end

  // driver: launch one op, push its expected result, check latency/busy window.
  // poke re-asserts start with different operands mid-operation.
  task automatic run_op(input bit w8, input logic [1:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input bit poke);
    int dw;
    int first_done;
    int busy_cnt;
    dw         = w8 ? 8 : 32;
    first_done = 0;
    busy_cnt   = 0;
    if (w8) exp8_q.push_back({ed, eh[7:0], el[7:0]});
    else    exp32_q.push_back({ed, eh, el});
    @(negedge clk);
    op = opc;
    d1 = a;
    d2 = b;
    if (w8) start8 = 1'b1;
    else    start32 = 1'b1;
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;
    for (int k = 1; k <= dw + 2; k++) begin
      @(negedge clk);
      if (w8 ? busy8 : busy32) busy_cnt++;
      if ((w8 ? done8 : done32) && first_done == 0) first_done = k;
      if (poke && k == 5) begin
        op = OP_DIVU;
        d1 = 32'd1;
        d2 = 32'd1;
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
      end
      if (poke && k == 6) begin
        start8  = 1'b0;
        start32 = 1'b0;
      end
    end
    chk("done_latency", 64'(first_done), 64'(dw + 2));
    chk("busy_cycles", 64'(busy_cnt), 64'(dw + 1));
    @(negedge clk);
    chk("done_one_cycle", 64'(w8 ? done8 : done32), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst32 = 1'b1; rst8 = 1'b1;
    start32 = 1'b0; start8 = 1'b0;
    op = OP_MULT; d1 = '0; d2 = '0; wdata = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_div0", 64'(div0_32), 64'd0);
    rst32 = 1'b0;
    rst8  = 1'b0;

    // 32-bit directed vectors
    run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    run_op(0, OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    run_op(0, OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(0, OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 0);
    chk("div0_sticky", 64'(div0_32), 64'd1);
    run_op(0, OP_DIVU,  32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 0);
    run_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0);
    run_op(0, OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 0);
    run_op(0, OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 0);

    // flush mid-CALC, with a direct HI write attempted while busy
    @(negedge clk);
    op = OP_MULT; d1 = 32'd5; d2 = 32'd5; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin hi_we = 1'b1; wdata = 32'h1234; end
      if (k == 4) hi_we = 1'b0;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        chk("flush_busy", 64'(busy32), 64'd0);
      end
    end
    chk("flush_hi_kept", 64'(hi32), 64'hFFFF_FFF8);
    chk("flush_lo_kept", 64'(lo32), 64'hFFFF_FFFF);
    chk("flush_div0_cleared", 64'(div0_32), 64'd0);

    // direct writes in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1 hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(hi32), 64'h0000_ABCD);
    chk("mthi_lo_untouched", 64'(lo32), 64'hFFFF_FFFF);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk);
    #1 begin hi_we = 1'b0; lo_we = 1'b0; end
    @(negedge clk);
    chk("both_we_hi", 64'(hi32), 64'h5A5A_0F0F);
    chk("both_we_lo", 64'(lo32), 64'h5A5A_0F0F);

    // start and flush together in IDLE: nothing launches
    start32 = 1'b1; flush = 1'b1; op = OP_MULT; d1 = 32'd2; d2 = 32'd2;
    @(posedge clk);
    #1 begin start32 = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("idle_flush_blocks_start", 64'(busy32), 64'd0);
    repeat (40) @(negedge clk);
    chk("idle_flush_hi_kept", 64'(hi32), 64'h5A5A_0F0F);

    // 8-bit instance
    run_op(1, OP_MULTU, 32'hFF, 32'h02, 32'h01, 32'hFE, 1'b0, 0);
    @(negedge clk);
    op = OP_MULT; d1 = 32'd5; d2 = 32'd5; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst8 = 1'b1;
    #1;
    chk("rst8_busy", 64'(busy8), 64'd0);
    chk("rst8_done", 64'(done8), 64'd0);
    chk("rst8_div0", 64'(div0_8), 64'd0);
    chk("rst8_hi", 64'(hi8), 64'd0);
    chk("rst8_lo", 64'(lo8), 64'd0);
    @(negedge clk);
    rst8 = 1'b0;
    run_op(1, OP_DIV,  32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 0);
    run_op(1, OP_DIV,  32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 0);
    run_op(1, OP_DIVU, 32'h64, 32'h00, 32'h64, 32'hFF, 1'b1, 0);

    repeat (5) @(negedge clk);
    chk("exp32_q_drained", 64'(exp32_q.size()), 64'd0);
    chk("exp8_q_drained", 64'(exp8_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; the next generation of the single-cycle ALU, adding MULT/MULTU/DIV/DIVU and HI/LO state.
- Sits beside the ALU in the CPU datapath. Operands come from the register read ports, a start pulse comes from control, and results are held in the internal HI/LO registers.
- Multi-cycle with a busy/done handshake; the pipeline stalls on busy_o.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; minimum 4, must be even.
- CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  launch operation; sampled only in IDLE.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- data1_i  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- data2_i  in  DATA_WIDTH  rt operand (multiplier / divisor).
- flush_i  in  1  abort the in-flight operation.
- hi_we_i  in  1  direct HI write (MTHI).
- lo_we_i  in  1  direct LO write (MTLO).
- wdata_i  in  DATA_WIDTH  direct write data.
- busy_o  out  1  high in CALC and FIX.
- done_o  out  1  one-cycle pulse when HI/LO are updated.
- div0_o  out  1  sticky divide-by-zero flag for the last operation.
- hi_o  out  DATA_WIDTH  HI register.
- lo_o  out  DATA_WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-high. State returns to IDLE; hi_o, lo_o, busy_o, done_o, div0_o and the counter all go to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on start_i:
  - latch |operand| for signed ops, raw operands for unsigned ops;
  - latch result-sign flags; counter = DATA_WIDTH; clear div0_o.
- CALC: one iteration per cycle; counter decrements; at counter==1 -> FIX.
  - Multiply: radix-2 shift-add on a 2*DATA_WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: one cycle.
  - Signed MULT: negate the product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI/LO. -> DONE.
- DONE: done_o=1 for exactly one cycle. -> IDLE. A start_i in DONE is ignored.
- Latency: start_i at edge N gives done_o high in cycle N+DATA_WIDTH+2; HI/LO are valid in the same cycle.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*DATA_WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: no iterations are skipped (fixed latency). Result is LO = all ones, HI = original dividend, div0_o = 1 until the next start.
- Signed overflow (MIN / -1): LO = MIN, HI = 0, no flag; this falls out naturally from the magnitude path.
- start_i while busy_o: ignored; operands are not re-sampled.
- flush_i:
  - in CALC or FIX: -> IDLE next cycle, HI/LO unchanged, no done_o;
  - in IDLE with start_i: flush wins, nothing launches;
  - in DONE: no effect (results already written).
- Direct writes:
  - hi_we_i/lo_we_i take effect only in IDLE and are ignored in all other states;
  - hi_we_i and lo_we_i together write both registers;
  - start_i and a direct write in the same IDLE cycle: the write lands, then the op launches.
- hi_o/lo_o are driven straight from registers; no combinational path from inputs.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (IDLE, CALC, FIX, DONE);
  - helper functions abs_val and neg_val parameterised by width.
- Control and control decode are also updated to drive start_i/op_i; that change lives outside this block.
- One sub-module is natural: muldiv_step, the combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide) instantiated once. The FSM, counter and HI/LO stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o at cycle 34 after start; HI=0xFFFFFFFE, LO=0x00000001; busy_o high for cycles 1..33.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, div0_o=1; next DIVU 9/3 clears div0_o, LO=3, HI=0.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div0_o=0.
- MULT 5x5 with flush_i at cycle 10 -> no done_o, HI/LO keep prior values; start_i during busy ignored; hi_we_i with 0xABCD in IDLE -> hi_o=0xABCD; hi_we_i during CALC has no effect.
- Same stimulus at DATA_WIDTH=8 and reset asserted mid-CALC -> all outputs 0 immediately; MULTU 0xFF x 0x02 gives HI=0x01, LO=0xFE after 10 cycles.
